// File: rtl/fpu_result_sequencer_if.sv
// Issue, unit-completion and in-order result signals of fpu_result_sequencer.
// master = issuer/unit side, slave = the sequencer.
interface fpu_result_sequencer_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned OPW       = $clog2(NUM_UNITS),
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic                       In_Data_Valid;
  logic [OPW-1:0]             opcode;
  logic                       In_Ready;
  logic [NUM_UNITS*WIDTH-1:0] unit_Data_Out;
  logic [NUM_UNITS-1:0]       unit_Data_Out_Valid;
  logic [WIDTH-1:0]           Data_Out;
  logic                       Out_Data_Valid;
  logic                       Out_Error;
  logic                       Overflow;
  logic [OccW-1:0]            Occupancy;

  modport master (
    output In_Data_Valid, opcode, unit_Data_Out, unit_Data_Out_Valid,
    input  In_Ready, Data_Out, Out_Data_Valid, Out_Error, Overflow, Occupancy
  );

  modport slave (
    input  In_Data_Valid, opcode, unit_Data_Out, unit_Data_Out_Valid,
    output In_Ready, Data_Out, Out_Data_Valid, Out_Error, Overflow, Occupancy
  );
endinterface

// File: rtl/fpu_result_sequencer.sv
// Returns results of NUM_UNITS arithmetic units strictly in issue order, using an in-order
// opcode FIFO, one-deep per-unit holding registers and a per-head stall timeout.
module fpu_result_sequencer #(
  parameter int unsigned     WIDTH        = 32,
  parameter int unsigned     NUM_UNITS    = 2,
  parameter int unsigned     OPW          = $clog2(NUM_UNITS),
  parameter int unsigned     DEPTH        = 4,
  parameter int unsigned     TIMEOUT      = 15,
  parameter logic [WIDTH-1:0] INVALID_WORD = {WIDTH{1'b1}}
) (
  input logic                    clk,
  input logic                    rst,
  fpu_result_sequencer_if.slave  bus
);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  // Tag FIFO
  logic [OPW-1:0]  fifo_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  // Per-unit holding registers
  logic [WIDTH-1:0]     hold_q [NUM_UNITS];
  logic [WIDTH-1:0]     hold_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] hold_v_q, hold_v_d;
  logic [NUM_UNITS-1:0] drain;

  logic [WaitW-1:0] wait_q, wait_d;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_error_q, out_error_d;
  logic             overflow_q, overflow_d;

  logic             empty, full, push, pop;
  logic [OPW-1:0]   head_op;
  logic             head_illegal;
  logic             head_v;
  logic [WIDTH-1:0] head_data;

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CntW'(DEPTH));
    head_op      = fifo_q[rd_ptr_q];
    head_illegal = (32'(head_op) >= NUM_UNITS);
    push         = bus.In_Data_Valid && !full;

    // Loop mux keeps the lookup in range even for illegal opcodes
    head_v    = 1'b0;
    head_data = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (head_op == OPW'(i)) begin
        head_v    = hold_v_q[i];
        head_data = hold_q[i];
      end
    end

    pop         = 1'b0;
    drain       = '0;
    wait_d      = wait_q;
    data_out_d  = INVALID_WORD;
    out_valid_d = 1'b0;
    out_error_d = 1'b0;

    if (!empty) begin
      if (head_illegal) begin
        pop         = 1'b1;
        out_valid_d = 1'b1;
        out_error_d = 1'b1;
        wait_d      = '0;
      end else if (head_v) begin
        pop         = 1'b1;
        out_valid_d = 1'b1;
        data_out_d  = head_data;
        wait_d      = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
          drain[i] = (head_op == OPW'(i));
        end
      end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
        pop         = 1'b1;
        out_valid_d = 1'b1;
        out_error_d = 1'b1;
        wait_d      = '0;
      end else begin
        wait_d = wait_q + WaitW'(1);
      end
    end

    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // A drain in the same cycle frees the slot, so the new word is kept rather than dropped
  always_comb begin
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      hold_d[i]   = hold_q[i];
      hold_v_d[i] = hold_v_q[i] && !drain[i];
      if (bus.unit_Data_Out_Valid[i]) begin
        if (hold_v_q[i] && !drain[i]) begin
          overflow_d = 1'b1;
        end else begin
          hold_d[i]   = bus.unit_Data_Out[i*WIDTH +: WIDTH];
          hold_v_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_v_q    <= '0;
      wait_q      <= '0;
      data_out_q  <= INVALID_WORD;
      out_valid_q <= 1'b0;
      out_error_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      hold_v_q    <= hold_v_d;
      wait_q      <= wait_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_error_q <= out_error_d;
      overflow_q  <= overflow_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by pointers and hold_v_q
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.opcode;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      hold_q[i] <= hold_d[i];
    end
  end

  assign bus.In_Ready       = !full;
  assign bus.Data_Out       = data_out_q;
  assign bus.Out_Data_Valid = out_valid_q;
  assign bus.Out_Error      = out_error_q;
  assign bus.Overflow       = overflow_q;
  assign bus.Occupancy      = count_q;
endmodule

// File: tb/tb_fpu_result_sequencer.sv
// Directed and random checks of fpu_result_sequencer against a queue-based reference model.
module tb_fpu_result_sequencer;
  localparam int unsigned W     = 32;
  localparam int unsigned NU    = 3;
  localparam int unsigned OW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_result_sequencer_if #(.WIDTH(W), .NUM_UNITS(NU), .OPW(OW), .DEPTH(DEPTH)) bus ();

  fpu_result_sequencer #(
    .WIDTH(W), .NUM_UNITS(NU), .OPW(OW), .DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          tq[$];
  bit          hv[NU];
  logic [31:0] hd[NU];
  int          wcnt;
  logic        e_ovf, e_vld, e_err;
  logic [31:0] e_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic iv, input logic [OW-1:0] op,
                       input logic [NU-1:0] uv, input logic [NU*W-1:0] ud);
    bit drain[NU];
    bit ready;
    int h;
    if (r) begin
      tq.delete();
      for (int i = 0; i < NU; i++) hv[i] = 1'b0;
      wcnt = 0; e_ovf = 1'b0; e_vld = 1'b0; e_err = 1'b0; e_dout = 32'hFFFF_FFFF;
      return;
    end
    ready  = (tq.size() < DEPTH);
    e_dout = 32'hFFFF_FFFF; e_vld = 1'b0; e_err = 1'b0;
    for (int i = 0; i < NU; i++) drain[i] = 1'b0;
    if (tq.size() > 0) begin
      h = tq[0];
      if (h >= NU) begin
        e_vld = 1'b1; e_err = 1'b1; void'(tq.pop_front()); wcnt = 0;
      end else if (hv[h]) begin
        e_vld = 1'b1; e_dout = hd[h]; drain[h] = 1'b1; void'(tq.pop_front()); wcnt = 0;
      end else if (wcnt == TO - 1) begin
        e_vld = 1'b1; e_err = 1'b1; void'(tq.pop_front()); wcnt = 0;
      end else begin
        wcnt++;
      end
    end
    for (int i = 0; i < NU; i++) begin
      if (uv[i]) begin
        if (hv[i] && !drain[i]) e_ovf = 1'b1;
        else begin hd[i] = ud[i*W +: W]; hv[i] = 1'b1; end
      end else if (drain[i]) begin
        hv[i] = 1'b0;
      end
    end
    if (iv && ready) tq.push_back(int'(op));
  endtask

  task automatic check_all();
    check("data_out", bus.Data_Out, e_dout);
    check("out_valid", 32'(bus.Out_Data_Valid), 32'(e_vld));
    check("out_error", 32'(bus.Out_Error), 32'(e_err));
    check("overflow", 32'(bus.Overflow), 32'(e_ovf));
    check("occupancy", 32'(bus.Occupancy), 32'(tq.size()));
    check("in_ready", 32'(bus.In_Ready), 32'(tq.size() < DEPTH));
  endtask

  task automatic step(input logic r, input logic iv, input logic [OW-1:0] op,
                      input logic [NU-1:0] uv, input logic [NU*W-1:0] ud);
    rst                     = r;
    bus.In_Data_Valid       = iv;
    bus.opcode              = op;
    bus.unit_Data_Out_Valid = uv;
    bus.unit_Data_Out       = ud;
    model(r, iv, op, uv, ud);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic issue(input logic [OW-1:0] op);
    step(1'b0, 1'b1, op, '0, '0);
  endtask

  task automatic pulse(input int u, input logic [31:0] d);
    logic [NU*W-1:0] ud;
    ud = (NU*W)'(d) << (u * W);
    step(1'b0, 1'b0, '0, NU'(1) << u, ud);
  endtask

  initial begin
    logic [NU*W-1:0] rd;
    logic [NU-1:0]   ru;
    rst = 1'b1;
    bus.In_Data_Valid = 1'b0; bus.opcode = '0;
    bus.unit_Data_Out_Valid = '0; bus.unit_Data_Out = '0;

    // Reset, then idle
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);
    idle(1);
    check("rst_dout", bus.Data_Out, 32'hFFFF_FFFF);
    check("rst_valid", 32'(bus.Out_Data_Valid), 32'd0);
    check("rst_ready", 32'(bus.In_Ready), 32'd1);
    check("rst_occ", 32'(bus.Occupancy), 32'd0);
    check("rst_ovf", 32'(bus.Overflow), 32'd0);

    // Single op: issue c0, unit0 pulse c3, result c5
    issue(2'd0); idle(2); pulse(0, 32'h3F80_0000);
    check("single_early", 32'(bus.Out_Data_Valid), 32'd0);
    idle(1);
    check("single_valid", 32'(bus.Out_Data_Valid), 32'd1);
    check("single_data", bus.Data_Out, 32'h3F80_0000);
    check("single_err", 32'(bus.Out_Error), 32'd0);
    idle(1);
    check("single_once", 32'(bus.Out_Data_Valid), 32'd0);

    // Out-of-order completion returned in issue order
    issue(2'd1); issue(2'd0); pulse(0, 32'h4000_0000); idle(3); pulse(1, 32'h4040_0000);
    idle(1);
    check("ooo_first", bus.Data_Out, 32'h4040_0000);
    idle(1);
    check("ooo_second", bus.Data_Out, 32'h4000_0000);
    idle(2);

    // Fill, ignored fifth issue, drain with pointer wrap
    issue(2'd0); issue(2'd1); issue(2'd2); issue(2'd0);
    check("full_occ", 32'(bus.Occupancy), 32'd4);
    check("full_ready", 32'(bus.In_Ready), 32'd0);
    issue(2'd1);
    check("full_ignored", 32'(bus.Occupancy), 32'd4);
    step(1'b0, 1'b0, '0, 3'b111, {32'hC, 32'hB, 32'hA});
    idle(1);
    step(1'b0, 1'b1, 2'd1, 3'b001, 96'hD);
    idle(2);
    pulse(1, 32'hE);
    idle(3);
    check("drain_occ", 32'(bus.Occupancy), 32'd0);
    check("drain_ready", 32'(bus.In_Ready), 32'd1);

    // Timeout: result pulse 9 cycles after issue
    issue(2'd1); idle(7);
    check("to_early", 32'(bus.Out_Data_Valid), 32'd0);
    idle(1);
    check("to_valid", 32'(bus.Out_Data_Valid), 32'd1);
    check("to_err", 32'(bus.Out_Error), 32'd1);
    check("to_data", bus.Data_Out, 32'hFFFF_FFFF);
    check("to_occ", 32'(bus.Occupancy), 32'd0);

    // Illegal opcode
    issue(2'd3); idle(1);
    check("ill_valid", 32'(bus.Out_Data_Valid), 32'd1);
    check("ill_err", 32'(bus.Out_Error), 32'd1);
    idle(1);

    // Overflow, sticky, and first word kept
    pulse(0, 32'h1); pulse(0, 32'h2);
    check("ovf_set", 32'(bus.Overflow), 32'd1);
    issue(2'd0); idle(1);
    check("ovf_data", bus.Data_Out, 32'h1);
    check("ovf_sticky", 32'(bus.Overflow), 32'd1);
    step(1'b1, 1'b0, '0, '0, '0);
    check("ovf_clear", 32'(bus.Overflow), 32'd0);

    // Reset with pending tags and held results
    issue(2'd0); issue(2'd1); pulse(2, 32'h55);
    step(1'b1, 1'b0, '0, '0, '0);
    check("mid_rst_occ", 32'(bus.Occupancy), 32'd0);
    issue(2'd2); idle(4);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      ru = '0;
      for (int i = 0; i < NU; i++) ru[i] = ($urandom_range(0, 2) == 0);
      rd = {$urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 249) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), ru, rd);
    end
    idle(20);
    check("final_occ", 32'(bus.Occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
